spi_slave_fifo_rx: RTL and testbench
====================================

// Module: spi_slave_fifo_rx
// PURPOSE
//  Parametrised SPI slave receiver: DATA_W-bit words, all four SPI modes, RX FIFO with read handshake and overrun flag.
//  Sits between the external SPI pins and the colour/register logic; replaces the fixed 8-bit mode-0 receiver.
//  Every SPI input is oversampled in the system clock domain, gated by a sample-enable strobe.
// PARAMETERS
//  DATA_W       8  word width in bits, 4..32, shifted MSB first
//  FIFO_DEPTH   4  RX FIFO entries, power of 2, 2..16
//  SYNC_STAGES  2  synchroniser flops on sck, cs and mosi, 2..3
// PORTS
//  clk         in   1        system clock; all logic on posedge
//  reset       in   1        asynchronous, active-low reset
//  clk_en      in   1        sample enable; state advances only on clk cycles with clk_en=1
//  sck         in   1        SPI clock (async)
//  cs          in   1        chip select, active-low (async)
//  mosi        in   1        SPI data in (async)
//  cpol        in   1        clock idle level; latched on cs assertion
//  cpha        in   1        0 = sample on leading edge, 1 = sample on trailing edge; latched on cs assertion
//  rd_en       in   1        pop FIFO head
//  ovr_clr     in   1        clear overrun
//  rd_data     out  DATA_W   FIFO head, first-word fall-through; 0 when empty
//  rd_valid    out  1        FIFO not empty
//  overrun     out  1        sticky: a word was dropped because the FIFO was full
//  frame_words out  8        complete words received in the current/last frame; saturates at 255
//  tx_data     in   DATA_W   word to transmit (SPI_TX_EN)
//  tx_load     in   1        write tx_data into the holding register (SPI_TX_EN)
//  tx_ready    out  1        holding register empty (SPI_TX_EN)
//  miso        out  1        SPI data out (SPI_TX_EN)
// BEHAVIOUR
//  - Reset (async, while reset=0): rd_data=0, rd_valid=0, overrun=0, frame_words=0, miso=0, tx_ready=1. FIFO, bit counter and synchronisers cleared.
//  - Synchronisers use equal depth on sck, cs and mosi, so mosi stays aligned with sck. Edge detect compares the last two synced sck values.
//  - Leading edge = sck leaves the cpol level; trailing edge = sck returns to it.
//  - Sample edge = leading if cpha=0, trailing if cpha=1. cpol and cpha are latched on the synced cs falling edge. Changes mid-frame are ignored.
//  - States: IDLE (cs high) -> SHIFT (cs low).
//    - cs falling: bit_cnt=0, frame_words=0, enter SHIFT.
//    - SHIFT: each sample edge does shreg <= {shreg[DATA_W-2:0], mosi_sync}, bit_cnt+1.
//    - When bit_cnt reaches DATA_W, the word is pushed on the next enabled cycle, bit_cnt wraps to 0 and frame_words increments.
//    - rd_valid rises one clk after the push. Latency from synced sample edge to rd_valid: 2 enabled cycles.
//    - cs rising mid-word: partial word discarded, bit_cnt=0, return to IDLE. frame_words holds its value until the next cs falling edge.
//  - FIFO pop: rd_en with rd_valid=1 pops on the same clk (not gated by clk_en). rd_en while empty is ignored.
//  - Push while full: word dropped, overrun<=1, FIFO unchanged.
//  - Push and pop in the same cycle while full: pop first, push accepted, overrun unchanged.
//  - ovr_clr clears overrun. If ovr_clr coincides with a dropping push, overrun stays 1.
//  - Pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are decided by the MSB compare. Pointers wrap modulo 2*FIFO_DEPTH.
//  - Maximum sck rate: f(clk_en) / (2*(SYNC_STAGES+2)). A faster sck is unsupported and not detected.
// CONFIGURATION
//  - SPI_TX_EN defined:
//    - tx_load with tx_ready=1 loads the holding register and drops tx_ready.
//    - On cs falling, and at each word boundary, holding -> shift-out register. tx_ready returns to 1.
//    - If the holding register is empty at transfer time, an all-zero word is sent.
//    - miso is driven from the shift-out MSB and shifts on the non-sample edge. With cpha=0 the first bit is valid at cs assertion.
//    - tx_load while tx_ready=0 is ignored.
//  - SPI_TX_EN undefined: miso=0 constant, tx_ready=0, tx_data and tx_load ignored. No TX flops.
// TESTING
//  1. Mode 0, DATA_W=8: one frame carrying 0xA5 then 0x3C -> rd_valid=1, pops return 0xA5 then 0x3C, frame_words=2, overrun=0.
//  2. Same bytes in modes 1, 2 and 3 with matching cpol/cpha -> identical rd_data. cpol toggled mid-frame -> no effect.
//  3. cs raised after 5 bits of 0x5A, then a new frame with 0xFF -> only 0xFF is pushed, frame_words=1.
//  4. FIFO_DEPTH=4: 5 words 0x01..0x05 with no reads -> pops give 0x01..0x04, overrun=1. ovr_clr -> overrun=0.
//  5. Full FIFO, push and rd_en in the same cycle -> 0x05 accepted, overrun stays 0. Also reset=0 mid-word with clk stopped -> all outputs at reset values.
//  6. SPI_TX_EN, mode 0: tx_data=0xC3 loaded -> miso bits 1,1,0,0,0,0,1,1. tx_ready=1 after the transfer. Second word with no load -> miso all 0.

Source files
------------

// File: rtl/spi_slave_fifo_rx.sv
// SPI slave receiver: DATA_W-bit words in any SPI mode, oversampled on clk, into a first-word
// fall-through RX FIFO with sticky overrun. Define SPI_TX_EN to add the MISO transmit path.
module spi_slave_fifo_rx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              rd_en,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overrun,
  output logic [7:0]        frame_words,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              miso,
  output logic              fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d, sck_s, cs_s, mosi_s;
  logic cpol_l, cpha_l;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] shreg;

  // Equal depth on all three pins keeps mosi aligned with the sck edge it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else if (clk_en) begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic cs_fall, sck_chg, lead_edge, trail_edge, sample, word_done, push;
  assign cs_fall    = cs_d & ~cs_s;
  assign sck_chg    = sck_s ^ sck_d;
  assign lead_edge  = sck_chg & (sck_d == cpol_l);
  assign trail_edge = sck_chg & (sck_s == cpol_l);
  assign sample     = (state == SHIFT) & (cpha_l ? trail_edge : lead_edge);
  assign word_done  = (bit_cnt == FULL_CNT);
  assign push       = clk_en & word_done;
  assign fsm_state  = (state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else if (clk_en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall) state_nx = SHIFT;
      SHIFT:   if (cs_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A completed word is still pushed even if cs rises in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_words <= '0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
    end else if (clk_en) begin
      if (cs_fall) begin
        bit_cnt     <= '0;
        frame_words <= '0;
        cpol_l      <= cpol;
        cpha_l      <= cpha;
      end else begin
        if (word_done && frame_words != 8'hFF) frame_words <= frame_words + 8'd1;
        if (state == SHIFT && cs_s) begin
          bit_cnt <= '0;
        end else if (sample) begin
          shreg   <= {shreg[DATA_W-2:0], mosi_s};
          bit_cnt <= word_done ? CNT_ONE : bit_cnt + CNT_ONE;
        end else if (word_done) begin
          bit_cnt <= '0;
        end
      end
    end
  end

  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | pop);

  // Pops are a system-side handshake and ignore clk_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      mem     <= '{default: '0};
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (push && full && !pop) overrun <= 1'b1;
      else if (ovr_clr)         overrun <= 1'b0;
    end
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef SPI_TX_EN
  logic [DATA_W-1:0] hold, tx_shreg;
  logic hold_full, shift_out, tx_xfer;

  assign shift_out = (state == SHIFT) & (cpha_l ? lead_edge : trail_edge);
  assign tx_xfer   = clk_en & (cs_fall | word_done);

  // No shift while bit_cnt is 0, so the MSB loaded at a boundary survives the first non-sample edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      tx_shreg  <= '0;
      hold_full <= 1'b0;
    end else begin
      if (tx_xfer) begin
        tx_shreg  <= hold_full ? hold : '0;
        hold_full <= 1'b0;
      end else if (clk_en && shift_out && bit_cnt != '0) begin
        tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
      end
      if (tx_load && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign miso     = tx_shreg[DATA_W-1];
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_load};
  assign tx_ready  = 1'b0;
  assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fifo_rx.sv
// Bench for spi_slave_fifo_rx: SPI master driver tasks, a word-level FIFO/overrun model and a
// per-cycle compare process active whenever the SPI side is quiet.
module tb_spi_slave_fifo_rx;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = 16;

  logic clk = 1'b0, reset = 1'b0, clk_en = 1'b1;
  logic sck = 1'b0, cs = 1'b1, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic rd_en = 1'b0, ovr_clr = 1'b0, tx_load = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic [W-1:0] rd_data;
  logic rd_valid, overrun, tx_ready, miso, fsm_state;
  logic [7:0] frame_words;

  bit clk_run = 1'b1, en_toggle = 1'b0, check_en = 1'b0;
  int errors = 0, checks = 0;

  logic [W-1:0] exp_q[$];
  logic exp_ovr = 1'b0;
  int exp_fw = 0;
  logic [W-1:0] frame_buf [8];
  logic [W-1:0] miso_cap [8];

  spi_slave_fifo_rx #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sck(sck), .cs(cs), .mosi(mosi),
    .cpol(cpol), .cpha(cpha), .rd_en(rd_en), .ovr_clr(ovr_clr), .rd_data(rd_data),
    .rd_valid(rd_valid), .overrun(overrun), .frame_words(frame_words), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .miso(miso), .fsm_state(fsm_state)
  );

  // clock / reset infrastructure
  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk) begin
    #1;
    clk_en = en_toggle ? ~clk_en : 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard compare: every quiet cycle
  always @(negedge clk) begin
    if (reset && check_en) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      chk("rd_data", rd_data, exp_q.size() != 0 ? exp_q[0] : '0);
      chk("overrun", overrun, exp_ovr);
      chk("frame_words", frame_words, exp_fw);
`ifndef SPI_TX_EN
      chk("miso_const", miso, 0);
      chk("tx_ready_const", tx_ready, 0);
`endif
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // probe: 1 = latency check on first word, 2 = pop in the push cycle of the last word (mode 0 only)
  task automatic spi_frame(input int nwords, input int abort_bits, input bit cp, input bit ch,
                           input bit mid_toggle, input int probe);
    int nbits, complete;
    logic [W-1:0] w, pv;
    check_en = 1'b0;
    cpol = cp; cpha = ch; sck = cp; cs = 1'b1;
    tick(HALF);
    cs = 1'b0;
    tick(HALF);
    nbits = (abort_bits >= 0) ? abort_bits : nwords * W;
    for (int b = 0; b < nbits; b++) begin
      w = frame_buf[b / W];
      if (!ch) mosi = w[W-1 - (b % W)];
      tick(HALF);
      if (!ch) miso_cap[b / W][W-1 - (b % W)] = miso;
      sck = ~cp;
      if (ch) mosi = w[W-1 - (b % W)];
      if (mid_toggle && b == 0) cpol = ~cp;
      if (probe == 1 && b == W - 1) begin
        repeat (4) @(negedge clk);
        chk("latency_before", rd_valid, 0);
        @(negedge clk);
        chk("latency_at", rd_valid, 1);
        @(posedge clk); #1;
        tick(HALF - 5);
      end else if (probe == 2 && b == nbits - 1) begin
        tick(3);
        rd_en = 1'b1;
        @(negedge clk);
        chk("simul_pop_data", rd_data, 8'h01);
        @(posedge clk); #1;
        rd_en = 1'b0;
        pv = exp_q.pop_front();
        chk("simul_pop_model", pv, 8'h01);
        tick(HALF - 4);
      end else begin
        tick(HALF);
      end
      if (ch) miso_cap[b / W][W-1 - (b % W)] = miso;
      sck = cp;
    end
    tick(HALF);
    cs = 1'b1;
    tick(HALF);
    cpol = cp;
    complete = nbits / W;
    for (int k = 0; k < complete; k++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(frame_buf[k]);
      else exp_ovr = 1'b1;
    end
    exp_fw = complete > 255 ? 255 : complete;
    tick(4);
    check_en = 1'b1;
  endtask

  task automatic do_pop;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pop_lit(input string name, input logic [W-1:0] val);
    @(negedge clk);
    chk(name, rd_data, val);
    chk({name, "_model"}, exp_q.size() != 0 ? exp_q[0] : '0, val);
    @(posedge clk); #1;
    do_pop();
  endtask

  task automatic drain;
    while (exp_q.size() != 0) do_pop();
    tick(2);
  endtask

  task automatic clear_ovr;
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    logic [1:0] mode;
    int nw, ab;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_words", frame_words, 0);
    chk("rst_miso", miso, 0);
`ifdef SPI_TX_EN
    chk("rst_tx_ready", tx_ready, 1);
`else
    chk("rst_tx_ready", tx_ready, 0);
`endif
    reset = 1'b1;
    tick(4);
    chk("idle_state", fsm_state, 0);
    check_en = 1'b1;

    // mode 0, two words, with rd_valid latency probe
    frame_buf[0] = 8'hA5; frame_buf[1] = 8'h3C;
    spi_frame(2, -1, 1'b0, 1'b0, 1'b0, 1);
    chk("t1_frame_words", frame_words, 8'd2);
    chk("t1_overrun", overrun, 0);
    pop_lit("t1_pop0", 8'hA5);
    pop_lit("t1_pop1", 8'h3C);

    // modes 1..3, cpol toggled mid-frame in mode 2
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      spi_frame(2, -1, mode[1], mode[0], m == 2, 0);
      pop_lit("t2_pop0", 8'hA5);
      pop_lit("t2_pop1", 8'h3C);
    end

    // aborted partial word then a fresh frame
    frame_buf[0] = 8'h5A;
    spi_frame(1, 5, 1'b0, 1'b0, 1'b0, 0);
    frame_buf[0] = 8'hFF;
    spi_frame(1, -1, 1'b0, 1'b0, 1'b0, 0);
    chk("t3_frame_words", frame_words, 8'd1);
    pop_lit("t3_pop", 8'hFF);
    tick(1);
    chk("t3_empty", rd_valid, 0);

    // overflow: five words into four entries
    for (int k = 0; k < 5; k++) frame_buf[k] = 8'(k + 1);
    spi_frame(5, -1, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_overrun", overrun, 1);
    chk("t4_frame_words", frame_words, 8'd5);
    for (int k = 0; k < 4; k++) pop_lit("t4_pop", 8'(k + 1));
    tick(1);
    chk("t4_overrun_held", overrun, 1);
    clear_ovr();
    tick(1);
    chk("t4_overrun_clr", overrun, 0);

    // full FIFO, pop in the same cycle as the push
    spi_frame(4, -1, 1'b0, 1'b0, 1'b0, 0);
    frame_buf[0] = 8'h05;
    spi_frame(1, -1, 1'b0, 1'b0, 1'b0, 2);
    chk("t5_overrun", overrun, 0);
    for (int k = 2; k < 6; k++) pop_lit("t5_pop", 8'(k));

`ifdef SPI_TX_EN
    tx_data = 8'hC3; tx_load = 1'b1;
    tick(1);
    tx_data = 8'h11;
    tick(1);
    tx_load = 1'b0;
    chk("tx_ready_loaded", tx_ready, 0);
    frame_buf[0] = 8'h12; frame_buf[1] = 8'h34;
    spi_frame(2, -1, 1'b0, 1'b0, 1'b0, 0);
    chk("tx_word0", miso_cap[0], 8'hC3);
    chk("tx_word1", miso_cap[1], 8'h00);
    chk("tx_ready_after", tx_ready, 1);
    drain();
`endif

    // randomized frames with interleaved pops, clears and a clk_en-throttled phase
    for (int f = 0; f < 10; f++) begin
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) frame_buf[k] = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nw * W - 1) : -1;
      mode = 2'($urandom_range(0, 3));
      en_toggle = (f >= 7);
      spi_frame(nw, ab, mode[1], mode[0], $urandom_range(0, 1) == 1, 0);
      repeat ($urandom_range(0, DEPTH + 1)) do_pop();
      if ($urandom_range(0, 2) == 0) clear_ovr();
      tick(2);
    end
    en_toggle = 1'b0;
    tick(4);
    drain();
    clear_ovr();

    // reset mid-word with the clock stopped
    for (int k = 0; k < 5; k++) frame_buf[k] = 8'(k + 16);
    spi_frame(5, -1, 1'b0, 1'b0, 1'b0, 0);
    check_en = 1'b0;
    cs = 1'b0;
    tick(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi = b[0];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(2);
    chk("pre_rst_state", fsm_state, 1);
    chk("pre_rst_overrun", overrun, 1);
    clk_run = 1'b0;
    #20 reset = 1'b0;
    #20;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_frame_words", frame_words, 0);
    chk("arst_miso", miso, 0);
    chk("arst_state", fsm_state, 0);
`ifdef SPI_TX_EN
    chk("arst_tx_ready", tx_ready, 1);
`else
    chk("arst_tx_ready", tx_ready, 0);
`endif
    cs = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fw = 0;
    #10 reset = 1'b1;
    clk_run = 1'b1;
    tick(6);
    check_en = 1'b1;
    frame_buf[0] = 8'h96;
    spi_frame(1, -1, 1'b1, 1'b1, 1'b0, 0);
    pop_lit("post_rst_pop", 8'h96);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
